// File: rtl/combo_lock_ctrl.sv
// Three-stage two-digit combination lock sequencer with failed-attempt lockout.
// Optional macro COMBO_LOCK_PROGRAM_EN adds a reprogrammable code register.
module combo_lock_ctrl #(
    parameter logic [7:0] CODE0          = 8'h28,
    parameter logic [7:0] CODE1          = 8'h19,
    parameter logic [7:0] CODE2          = 8'h96,
    parameter int         MAX_FAILS      = 3,
    parameter int         LOCKOUT_CYCLES = 1000
) (
    input  logic        clock_i,
    input  logic        reset_ni,
    input  logic        enter_i,
    input  logic [3:0]  digit_a_i,
    input  logic [3:0]  digit_b_i,
    input  logic        prog_i,
    output logic [1:0]  stage_o,
    output logic [1:0]  result_o,
    output logic        unlocked_o,
    output logic        alarm_o,
    output logic [2:0]  fail_count_o,
    output logic [23:0] lockout_remaining_o,
    output logic [23:0] code_log_o
);
    // state      | meaning
    // S_E0..S_E2 | awaiting pair k
    // S_VERIFY   | one-cycle compare of all three match bits
    // S_UNLOCKED | open, waiting for acknowledge enter
    // S_FAIL     | wrong combination, waiting for acknowledge enter
    // S_LOCKOUT  | too many failures, timed alarm
    typedef enum logic [2:0] {
        S_E0, S_E1, S_E2, S_VERIFY, S_UNLOCKED, S_FAIL, S_LOCKOUT
    } state_t;

    localparam logic [2:0]  MAX_F     = 3'(MAX_FAILS);
    localparam logic [23:0] LOCK_INIT = 24'(LOCKOUT_CYCLES);

    state_t      state_q, state_d;
    logic [2:0]  fail_q, fail_d, fail_inc;
    logic [23:0] lock_q, lock_d;
    logic [23:0] log_q, log_d;
    logic [2:0]  match_q, match_d;
    logic [1:0]  stage_q, stage_d, result_q, result_d;
    logic        unlocked_q, unlocked_d, alarm_q, alarm_d;
    logic [7:0]  pair;
    logic        pair_ok;
    logic [2:0][7:0] code_c;

    assign pair     = {digit_a_i, digit_b_i};
    assign pair_ok  = (digit_a_i <= 4'd9) && (digit_b_i <= 4'd9) && (pair != 8'h00);
    assign fail_inc = (fail_q >= MAX_F) ? MAX_F : fail_q + 3'd1;

`ifdef COMBO_LOCK_PROGRAM_EN
    logic [2:0][7:0] code_q, code_d;
    logic [1:0]      ptr_q, ptr_d;
    assign code_c = code_q;
`else
    logic unused_prog;
    assign unused_prog = prog_i;
    assign code_c = {CODE2, CODE1, CODE0};
`endif

    always_comb begin
        state_d = state_q;
        fail_d  = fail_q;
        lock_d  = lock_q;
        log_d   = log_q;
        match_d = match_q;
`ifdef COMBO_LOCK_PROGRAM_EN
        code_d  = code_q;
        ptr_d   = ptr_q;
`endif
        case (state_q)
            S_E0, S_E1, S_E2: begin
                if (enter_i) begin
                    if (pair_ok) begin
                        case (state_q)
                            S_E0: begin
                                log_d[23:16] = pair;
                                match_d[0]   = (pair == code_c[0]);
                                state_d      = S_E1;
                            end
                            S_E1: begin
                                log_d[15:8]  = pair;
                                match_d[1]   = (pair == code_c[1]);
                                state_d      = S_E2;
                            end
                            default: begin
                                log_d[7:0]   = pair;
                                match_d[2]   = (pair == code_c[2]);
                                state_d      = S_VERIFY;
                            end
                        endcase
                    end else begin
                        state_d = S_E0;
                        log_d   = '0;
                        match_d = '0;
                    end
                end
            end
            S_VERIFY: begin
                if (&match_q) begin
                    state_d = S_UNLOCKED;
                    fail_d  = '0;
                end else begin
                    fail_d = fail_inc;
                    if (fail_inc == MAX_F) begin
                        state_d = S_LOCKOUT;
                        lock_d  = LOCK_INIT;
                    end else begin
                        state_d = S_FAIL;
                    end
                end
            end
            S_UNLOCKED: begin
`ifdef COMBO_LOCK_PROGRAM_EN
                if (enter_i && prog_i) begin
                    if (pair_ok) begin
                        code_d[ptr_q] = pair;
                        ptr_d = (ptr_q == 2'd2) ? 2'd0 : ptr_q + 2'd1;
                    end
                end else if (enter_i) begin
                    state_d = S_E0;
                    log_d   = '0;
                    match_d = '0;
                    ptr_d   = '0;
                end
`else
                if (enter_i) begin
                    state_d = S_E0;
                    log_d   = '0;
                    match_d = '0;
                end
`endif
            end
            S_FAIL: begin
                if (enter_i) begin
                    state_d = S_E0;
                    log_d   = '0;
                    match_d = '0;
                end
            end
            S_LOCKOUT: begin
                // enter is deliberately not looked at here
                if (lock_q == 24'd1) begin
                    state_d = S_E0;
                    lock_d  = '0;
                    fail_d  = '0;
                    log_d   = '0;
                    match_d = '0;
                end else begin
                    lock_d = lock_q - 24'd1;
                end
            end
            default: state_d = S_E0;
        endcase
    end

    always_comb begin
        stage_d    = 2'd3;
        result_d   = 2'b00;
        unlocked_d = 1'b0;
        alarm_d    = 1'b0;
        case (state_d)
            S_E0:       stage_d = 2'd0;
            S_E1:       stage_d = 2'd1;
            S_E2:       stage_d = 2'd2;
            S_UNLOCKED: begin result_d = 2'b01; unlocked_d = 1'b1; end
            S_FAIL:     result_d = 2'b10;
            S_LOCKOUT:  begin result_d = 2'b11; alarm_d = 1'b1; end
            default:    ;
        endcase
    end

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q    <= S_E0;
            fail_q     <= '0;
            lock_q     <= '0;
            log_q      <= '0;
            match_q    <= '0;
            stage_q    <= '0;
            result_q   <= '0;
            unlocked_q <= 1'b0;
            alarm_q    <= 1'b0;
`ifdef COMBO_LOCK_PROGRAM_EN
            code_q     <= {CODE2, CODE1, CODE0};
            ptr_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            fail_q     <= fail_d;
            lock_q     <= lock_d;
            log_q      <= log_d;
            match_q    <= match_d;
            stage_q    <= stage_d;
            result_q   <= result_d;
            unlocked_q <= unlocked_d;
            alarm_q    <= alarm_d;
`ifdef COMBO_LOCK_PROGRAM_EN
            code_q     <= code_d;
            ptr_q      <= ptr_d;
`endif
        end
    end

    assign stage_o             = stage_q;
    assign result_o            = result_q;
    assign unlocked_o          = unlocked_q;
    assign alarm_o             = alarm_q;
    assign fail_count_o        = fail_q;
    assign lockout_remaining_o = lock_q;
    assign code_log_o          = log_q;

endmodule

// File: doc/combo_lock_ctrl.md
Name: combo_lock_ctrl

Overview:
- Sequencer for the three-stage two-digit combination lock.
- Accepts debounced digit-pair entries from the switch inputs and tracks the entry stage.
- Compares each pair against the stored combination and decides unlock or fail.
- Counts failed attempts and enforces a timed lockout; drives stage, result and entered-digit log to the 7-segment display datapath.

Parameters:
- CODE0, 8'h28, stage-0 combination {tens,units} BCD
- CODE1, 8'h19, stage-1 combination
- CODE2, 8'h96, stage-2 combination
- MAX_FAILS, 3, consecutive failed attempts that trigger lockout (1..7)
- LOCKOUT_CYCLES, 1000, lockout duration in clock cycles (>=2, fits 24 bits)

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- enter  in  1  single-cycle strobe, already debounced/edge-detected
- digit_a  in  4  tens digit (BCD)
- digit_b  in  4  units digit (BCD)
- prog  in  1  program strobe (used only with COMBO_LOCK_PROGRAM_EN)
- stage  out  2  0..2 = awaiting pair k; 3 = result/lockout
- result  out  2  00 entering, 01 unlocked, 10 failed, 11 lockout
- unlocked  out  1  high in UNLOCKED
- alarm  out  1  high in LOCKOUT
- fail_count  out  3  consecutive failed attempts
- lockout_remaining  out  24  cycles left in lockout, 0 otherwise
- code_log  out  24  entered pairs {pair0,pair1,pair2}; unentered pairs read 0

Behaviour:
- Reset (async assert, sync release):
  - State S_E0; stage=0, result=00, unlocked=0, alarm=0.
  - fail_count=0, lockout_remaining=0, code_log=0, match bits=0.
  - Programmed code reverts to the CODEx parameters.
- All outputs are registered. An enter sampled at edge N is reflected after edge N.
- Valid pair: digit_a<=9, digit_b<=9, and {digit_a,digit_b}!=8'h00.
- States: S_E0, S_E1, S_E2, S_VERIFY, S_UNLOCKED, S_FAIL, S_LOCKOUT.
- S_Ek (k=0..2), enter with a valid pair:
  - Store the pair in code_log slot k.
  - Set match[k] = (pair==CODEk).
  - Advance to S_E(k+1), or to S_VERIFY from S_E2.
- S_Ek, enter with an invalid pair (abort):
  - Go to S_E0; clear code_log and match.
  - fail_count unchanged.
- S_VERIFY (exactly one cycle, stage=3, result=00):
  - &match -> S_UNLOCKED; fail_count cleared.
  - Otherwise fail_count+1. If the new value equals MAX_FAILS, go to S_LOCKOUT and load lockout_remaining=LOCKOUT_CYCLES. Else go to S_FAIL.
  - Third enter at edge N: unlocked/result visible after edge N+1.
- S_UNLOCKED / S_FAIL:
  - Hold until enter, regardless of digit values. That enter is consumed as an acknowledge, not data.
  - On enter -> S_E0; clear code_log and match.
- S_LOCKOUT:
  - alarm=1. lockout_remaining decrements by 1 each cycle.
  - enter is ignored, including on the cycle lockout_remaining reaches 1.
  - On the cycle lockout_remaining==1: next state S_E0, lockout_remaining=0, fail_count=0, code_log cleared.
- fail_count saturates at MAX_FAILS and never wraps.
- enter asserted during S_VERIFY is ignored.
- Reset asserted mid-entry or mid-lockout: immediate return to reset values. A lockout is not resumed after reset.

Optional Feature:
- Macro: COMBO_LOCK_PROGRAM_EN.
- Defined:
  - In S_UNLOCKED, prog high on an enter cycle, with a valid pair, writes that pair into the programmed-code register for slot p, where p is a 2-bit pointer starting at 0.
  - The state stays S_UNLOCKED and p increments. After slot 2 is written, p returns to 0.
  - An invalid pair with prog is ignored.
  - Plain enter without prog relocks as normal and resets p.
  - Comparisons use the programmed register (reset value = CODEx).
- Undefined:
  - prog is ignored (left unconnected internally).
  - Comparisons use the CODEx constants directly.
  - No code register is synthesized.

Test Plan:
- Reset, then enter pairs 28, 19, 96 -> stage 0->1->2->3, code_log=24'h281996, unlocked=1 and result=01 one cycle after the third enter, fail_count=0.
- Enter 28, 19, 95 -> result=10, fail_count=1. Next enter -> S_E0, code_log=0, stage=0.
- LOCKOUT_CYCLES=8, MAX_FAILS=3; three wrong attempts -> result=11, alarm=1, lockout_remaining counts 8..1. Enters during lockout are ignored. Then stage=0, fail_count=0, alarm=0.
- Enter 28, then pair 0A (invalid), then 00 (invalid) -> each returns to S_E0 with code_log=0 and fail_count unchanged.
- Two failures, then a correct sequence -> unlocked=1, fail_count cleared to 0. Assert reset mid-entry (after pair 28) -> all outputs at reset values immediately.
- With COMBO_LOCK_PROGRAM_EN: unlock, then prog+enter with 11, 22, 33, then relock. Sequence 28, 19, 96 -> fail. Sequence 11, 22, 33 -> unlocked.
